// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_REDIR,
    SEL_MISALIGN_TRAP,
    SEL_SEQ,
    SEL_HOLD
  } pc_sel_e;

  // Only the two lowest address bits matter for the legal alignments (2 or 4 bytes).
  function automatic logic pc_aligned(input logic [1:0] addr_lo, input int unsigned ialign);
    if (ialign == 2) return (addr_lo[0] == 1'b0);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select for the RUN state: trap, redirect,
// misaligned redirect (vectored to the trap handler), halt, sequential, hold.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 4
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  input  logic            pc_ready_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            halt_req_i,
  output logic [XLEN-1:0] pc_next_o,
  output pc_sel_e         sel_o,
  output logic            halt_o
);

  logic [XLEN-1:0] trap_al;
  assign trap_al = trap_vec_i & ~XLEN'(IALIGN - 1);

  // A halt that collides with a flush loses this cycle and is re-evaluated next edge.
  always_comb begin
    pc_next_o = pc_i;
    sel_o     = SEL_HOLD;
    halt_o    = 1'b0;
    if (trap_valid_i) begin
      pc_next_o = trap_al;
      sel_o     = SEL_TRAP;
    end else if (redirect_valid_i) begin
      if (pc_aligned(redirect_pc_i[1:0], IALIGN)) begin
        pc_next_o = redirect_pc_i;
        sel_o     = SEL_REDIR;
      end else begin
        pc_next_o = trap_al;
        sel_o     = SEL_MISALIGN_TRAP;
      end
    end else if (halt_req_i) begin
      halt_o = 1'b1;
    end else if (pc_valid_i && pc_ready_i && !stall_i) begin
      pc_next_o = pc_i + XLEN'(IALIGN);
      sel_o     = SEL_SEQ;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: boot sequencing, fetch handshake, stall hold,
// branch/trap redirect with misalignment check and debug halt/resume.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              IALIGN    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  output logic            misalign,
  output logic            halted
);

  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            pc_valid_q;
  logic            misalign_q;
  logic            halted_q;
  pc_sel_e         sel;
  logic            halt_go;

  pc_next_mux #(
    .XLEN  (XLEN),
    .IALIGN(IALIGN)
  ) u_next (
    .pc_i            (pc_q),
    .pc_valid_i      (pc_valid_q),
    .pc_ready_i      (pc_ready),
    .stall_i         (stall),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .trap_valid_i    (trap_valid),
    .trap_vec_i      (trap_vec),
    .halt_req_i      (halt_req),
    .pc_next_o       (pc_d),
    .sel_o           (sel),
    .halt_o          (halt_go)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
        end
        ST_RUN: begin
          pc_q       <= pc_d;
          misalign_q <= (sel == SEL_MISALIGN_TRAP);
          if (halt_go) begin
            state_q    <= ST_HALTED;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b1;
          end
        end
        ST_HALTED: begin
          // Resume wins over a debugger PC write in the same cycle.
          if (resume) begin
            state_q    <= ST_RUN;
            pc_valid_q <= 1'b1;
            halted_q   <= 1'b0;
          end else if (redirect_valid) begin
            if (pc_aligned(redirect_pc[1:0], IALIGN)) pc_q <= redirect_pc;
            else misalign_q <= 1'b1;
          end
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign misalign = misalign_q;
  assign halted   = halted_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It replaces the plain reset/load PC register with a sequential unit with these features:
- boot sequencing
- a valid/ready fetch handshake
- stall hold
- branch redirect with a misalignment check
- trap vectoring
- a debug halt/resume state machine

It sits between the execute/trap logic, which supplies targets, and the instruction-fetch interface, which consumes `pc`.

## Interface
- `XLEN`, 32: address width.
- `RESET_VEC`, 32'h0000_0000: first fetch address after reset. Must be `IALIGN`-aligned.
- `IALIGN`, 4: instruction alignment and sequential increment, in bytes. Legal values are 2 or 4.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `stall`  in  1  hold the current PC; suppresses sequential advance only.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  XLEN  redirect target.
- `trap_valid`  in  1  exception/interrupt taken this cycle.
- `trap_vec`  in  XLEN  trap handler base. The low log2(`IALIGN`) bits are ignored (treated as 0).
- `halt_req`  in  1  debug halt request.
- `resume`  in  1  debug resume request.
- `pc`  out  XLEN  current fetch address.
- `pc_valid`  out  1  fetch request valid.
- `pc_ready`  in  1  fetch unit accepts `pc` this cycle.
- `misalign`  out  1  one-cycle pulse: a redirect target was misaligned and a trap was taken instead.
- `halted`  out  1  high while in HALTED.

## Operation
States: BOOT, RUN, HALTED.

Reset (`rst`=0 at an edge):
- `pc`=`RESET_VEC`, `pc_valid`=0, `misalign`=0, `halted`=0, state=BOOT.
- This applies from any state, including mid-handshake.

BOOT:
- Unconditionally goes to RUN on the next edge.
- `pc` keeps `RESET_VEC`.
- `pc_valid` becomes 1 on entering RUN.

RUN: next-PC priority, highest first, evaluated each edge:
1. `trap_valid`: `pc` <= aligned `trap_vec`.
2. `redirect_valid` with `redirect_pc` aligned: `pc` <= `redirect_pc`.
3. `redirect_valid` with `redirect_pc` misaligned: `pc` <= aligned `trap_vec`; `misalign`=1 for that one cycle.
4. `halt_req`: state <= HALTED; `pc` held; `pc_valid` <= 0.
5. `pc_valid` & `pc_ready` & !`stall`: `pc` <= `pc` + `IALIGN`.
6. Otherwise: hold.

Further RUN rules:
- Trap and redirect ignore `stall`; they act as a flush.
- A `halt_req` coinciding with a trap or redirect is applied one cycle later, provided it is still asserted.
- Handshake: while `pc_valid` & !`pc_ready`, `pc` is stable. The only exceptions are trap/redirect, which the fetch unit treats as an abort of the outstanding request.
- Arithmetic: the increment is modulo 2^XLEN. `pc` = all-ones minus (`IALIGN`-1) wraps to 0 with no flag.
- Misaligned means `redirect_pc[log2(IALIGN)-1:0]` != 0.

HALTED:
- `pc_valid`=0 and `halted`=1.
- `trap_valid` and `stall` are ignored.
- `redirect_valid` loads `pc` (debugger PC write) with the same alignment check. Misaligned: `pc` unchanged, `misalign` pulses.
- `resume` causes state <= RUN and `pc_valid` <= 1 on the next edge.
- `resume` has priority over a simultaneous redirect; the redirect is dropped.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- First `pc_valid`=1 appears on the second edge after `rst` deasserts.
- Redirect/trap latency: new `pc` is visible the cycle after assertion.
- Sequential advance: one `IALIGN` step per accepted handshake, so the maximum rate is one fetch per cycle.
- `halt_req` to `pc_valid`=0 and `halted`=1 takes one cycle.
- `resume` to `pc_valid`=1 takes one cycle.

## Structure
- Shared package `pc_pkg` holds:
  - the state enum `pc_state_e` (BOOT, RUN, HALTED);
  - the next-PC select enum (TRAP, REDIR, MISALIGN_TRAP, SEQ, HOLD);
  - the function `pc_aligned(addr, ialign)`.
- One sub-module is natural: `pc_next_mux`, a combinational priority select that produces the next PC and the `misalign` condition.
- The FSM and the registers live in `pc_gen`.

## Test plan
- Reset release, `pc_ready`=1, no other inputs: `pc` sequence = 0, 0 (BOOT), 4, 8, 12; `pc_valid` rises on the second edge.
- `pc_valid`=1 with `pc_ready`=0 for 3 cycles, then 1: `pc` holds 0x10 for 3 cycles, then 0x14.
- Simultaneous `trap_valid` (`trap_vec`=0x103) and `redirect_valid` (0x200) while `stall`=1: `pc`=0x100 next cycle, `misalign`=0.
- `redirect_pc`=0x202 with `IALIGN`=4 and `trap_vec`=0x100: `pc`=0x100 and a single-cycle `misalign` pulse. With `IALIGN`=2: `pc`=0x202 and no pulse.
- Halt/resume sequence:
  - `halt_req` at `pc`=0x20: `halted`=1, `pc_valid`=0, `pc`=0x20.
  - Redirect 0x80 while halted: `pc`=0x80 with `pc_valid` still 0.
  - `resume`: `pc_valid`=1 at 0x80.
  - Then `rst`=0 mid-run: `pc`=`RESET_VEC`, state BOOT.
- `XLEN`=32, `pc`=0xFFFF_FFFC, advance: `pc`=0x0000_0000 with no flag.
